acc_drain: RTL and testbench
============================

Name: acc_drain

Overview:
- Downstream stage of the accumulator. After an accumulation pass it reads a contiguous address range through the accumulator's read port (1-cycle read latency).
- Each read word is split into DATA_WIDTH/LANE_WIDTH lanes, and each lane is reduced mod 2^logq by masking off its high bits.
- Reduced words are streamed out on a valid/ready interface toward the packer/output buffer.
- A 4-entry internal FIFO with credit-based read issue sustains 1 beat/cycle and absorbs backpressure without losing read data.

Parameters:
- ADDR_WIDTH, 9, accumulator address width.
- DATA_WIDTH, 64, accumulator word width.
- LANE_WIDTH, 16, coefficient lane width; DATA_WIDTH must be a multiple of it.
- FIFO_DEPTH, 4, output FIFO entries (minimum 3 for full throughput).

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first address, sampled with start.
- length  in  ADDR_WIDTH+1  number of words, sampled with start; 0 means an empty job.
- logq  in  5  modulus exponent, sampled with start; legal range 1..LANE_WIDTH.
- rd_en  out  1  accumulator read enable.
- rd_addr  out  ADDR_WIDTH  accumulator read address.
- rd_data  in  DATA_WIDTH  accumulator read data, valid 1 cycle after rd_en.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH  reduced word.
- m_last  out  1  marks the final beat of the job.
- busy  out  1  high while not IDLE.
- done  out  1  1-cycle pulse at job completion.

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=IDLE; all outputs 0.
  - FIFO, credit and in-flight counters cleared.
  - Reset mid-job aborts immediately; read data returning after rstn releases is discarded.
- States: IDLE, RUN, FLUSH.
- IDLE:
  - On start, latch base_addr, length and logq.
  - length=0: done=1 on the next cycle, remain in IDLE, no rd_en, no beats.
  - Otherwise go to RUN; busy=1 from the cycle after start.
  - start while busy is ignored.
- RUN:
  - Issue rd_en=1 with rd_addr=current address in any cycle where (FIFO occupancy + reads in flight) < FIFO_DEPTH.
  - Address increments mod 2^ADDR_WIDTH, so base 0x1FF wraps to 0x000.
  - A read issued in cycle k has its data written into the FIFO at the edge ending cycle k+1; it is visible on m_data in cycle k+2.
  - After the length-th read is issued, go to FLUSH.
- FLUSH:
  - No further rd_en.
  - When the beat carrying m_last is accepted (m_valid & m_ready), pulse done=1 for 1 cycle and return to IDLE; busy drops in the same cycle done is high.
- Timing:
  - First rd_en is asserted in the cycle after the start edge.
  - First m_valid comes 2 cycles after the first rd_en.
  - With m_ready held high: exactly length consecutive beats, 1 per cycle, no bubbles.
- Output handshake:
  - m_valid/m_data/m_last are driven from the FIFO head.
  - Once m_valid is asserted it holds, and data is stable, until m_ready.
  - m_ready low for any duration loses no data; rd_en throttles automatically via credits.
  - Beats never cross jobs; m_last is asserted only on beat number length.
- Reduction, per lane i:
  - out_lane = in_lane & ((1<<logq)-1).
  - logq=LANE_WIDTH passes the lane unchanged.
  - logq > LANE_WIDTH is clamped to LANE_WIDTH; logq=0 is treated as 1.
  - Purely combinational on FIFO write, so it adds no latency.
- Simultaneous FIFO push and pop in the same cycle is legal and leaves occupancy unchanged.

Test Plan:
- Preload addresses 0x10..0x13 with 0x0001_8002_FFFF_7FFF (all four words) via accumulator mode 0. Run start, base=0x10, len=4, logq=15, m_ready=1 -> 4 consecutive beats of 0x0001_0002_7FFF_7FFF; m_last on beat 4; done 1 cycle after beat 4 is accepted; rd_en high for 4 consecutive cycles.
- Same data, logq=16 -> data passes unchanged.
- Same data, logq=12 -> each word reads 0x0001_0002_0FFF_0FFF.
- base=0x1FE, len=4 -> rd_addr sequence 0x1FE, 0x1FF, 0x000, 0x001; beat order matches.
- len=8 with m_ready toggling 1,0,0,1 repeating and held low for 10 cycles mid-job -> all 8 words delivered in order, none lost or duplicated; occupancy + in-flight never exceeds 4.
- len=0 -> done 1 cycle after start, no rd_en, no m_valid. Separately: start again while busy -> ignored. Separately: rstn pulsed low mid-job -> outputs 0 immediately, and the next job runs correctly.

Source files
------------

// File: rtl/acc_drain.sv
// acc_drain: reads a contiguous accumulator range and reduces each lane
// mod 2^logq. Reduced words stream out on valid/ready. Reads are issued
// against credits from a small output FIFO, so backpressure never drops
// returning read data.
module acc_drain #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64,
    parameter int LANE_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic [4:0]            logq,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Lane mask keeping the low logq bits; logq=0 acts as 1, large values clamp.
    function automatic logic [LANE_WIDTH-1:0] lane_mask(input logic [4:0] q);
        logic [LANE_WIDTH-1:0] m;
        int eff;
        if (q == 5'd0) begin
            eff = 1;
        end else if (int'(q) > LANE_WIDTH) begin
            eff = LANE_WIDTH;
        end else begin
            eff = int'(q);
        end
        for (int i = 0; i < LANE_WIDTH; i++) begin
            m[i] = (i < eff) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    // Apply the lane mask to every lane of a word.
    function automatic logic [DATA_WIDTH-1:0] reduce_word(input logic [DATA_WIDTH-1:0] w,
                                                          input logic [LANE_WIDTH-1:0] m);
        logic [DATA_WIDTH-1:0] r;
        for (int l = 0; l < LANES; l++) begin
            r[l*LANE_WIDTH +: LANE_WIDTH] = w[l*LANE_WIDTH +: LANE_WIDTH] & m;
        end
        return r;
    endfunction

    // Circular pointer advance for arbitrary depth.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    state_t                  state_r, state_n_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH:0]     rd_rem_r;
    logic [ADDR_WIDTH:0]     out_rem_r;
    logic [LANE_WIDTH-1:0]   mask_r;
    logic                    infl_r;
    logic                    done_r, done_n_s;
    logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]           cnt_r;
    logic [CW:0]             used_s;
    logic                    issue_s, push_s, pop_s, valid_s, last_s, accept_s;

    // Credit check, handshake decode and next-state logic.
    always_comb begin
        state_n_s = state_r;
        done_n_s  = 1'b0;
        used_s    = {1'b0, cnt_r} + {{CW{1'b0}}, infl_r};
        valid_s   = (cnt_r != {CW{1'b0}});
        last_s    = valid_s && (out_rem_r == (ADDR_WIDTH+1)'(1));
        pop_s     = valid_s && m_ready;
        push_s    = infl_r;
        issue_s   = (state_r == ST_RUN) && (rd_rem_r != {(ADDR_WIDTH+1){1'b0}})
                    && (used_s < (CW+1)'(FIFO_DEPTH));
        accept_s  = (state_r == ST_IDLE) && start;
        case (state_r)
            ST_IDLE: begin
                if (start && (length == {(ADDR_WIDTH+1){1'b0}})) begin
                    done_n_s = 1'b1;
                end else if (start) begin
                    state_n_s = ST_RUN;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && (rd_rem_r == (ADDR_WIDTH+1)'(1))) begin
                    state_n_s = ST_FLUSH;
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (pop_s && last_s) begin
                    state_n_s = ST_IDLE;
                    done_n_s  = 1'b1;
                end else begin
                    state_n_s = ST_FLUSH;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // State register and done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            done_r  <= done_n_s;
        end
    end

    // Job parameters, read address/remaining counters and in-flight flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_r    <= {ADDR_WIDTH{1'b0}};
            rd_rem_r  <= {(ADDR_WIDTH+1){1'b0}};
            out_rem_r <= {(ADDR_WIDTH+1){1'b0}};
            mask_r    <= {LANE_WIDTH{1'b0}};
            infl_r    <= 1'b0;
        end else begin
            infl_r <= issue_s;
            if (accept_s) begin
                addr_r    <= base_addr;
                rd_rem_r  <= length;
                out_rem_r <= length;
                mask_r    <= lane_mask(logq);
            end else begin
                if (issue_s) begin
                    addr_r   <= addr_r + ADDR_WIDTH'(1);
                    rd_rem_r <= rd_rem_r - (ADDR_WIDTH+1)'(1);
                end
                if (pop_s) begin
                    out_rem_r <= out_rem_r - (ADDR_WIDTH+1)'(1);
                end
            end
        end
    end

    // Output FIFO: reduced read data pushed one cycle after issue, head popped on accept.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= reduce_word(rd_data, mask_r);
                wr_ptr_r        <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign rd_en   = issue_s;
    assign rd_addr = addr_r;
    assign m_valid = valid_s;
    assign m_data  = mem_r[rd_ptr_r];
    assign m_last  = last_s;
    assign busy    = (state_r != ST_IDLE);
    assign done    = done_r;

endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain: a behavioural accumulator memory with
// 1-cycle read latency, table-driven jobs, hand-written corner sequences and
// randomized jobs checked against a modulo-arithmetic reference model.
module tb_acc_drain;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  base_addr = 9'd0;
    logic [9:0]  length = 10'd0;
    logic [4:0]  logq = 5'd0;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [63:0] rd_data = 64'd0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    logic [63:0] acc_mem [512];
    int          n_checks = 0;
    int          n_fail = 0;

    acc_drain dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .length(length), .logq(logq), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Accumulator read port model: data one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= acc_mem[rd_addr];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: each 16-bit lane taken modulo 2^e, e = clamp(logq, 1, 16).
    function automatic logic [63:0] model_reduce(input logic [63:0] w, input int q);
        logic [63:0] r = 64'd0;
        logic [63:0] lane;
        int e = (q < 1) ? 1 : ((q > 16) ? 16 : q);
        for (int l = 0; l < 4; l++) begin
            lane = (w >> (16 * l)) & 64'hFFFF;
            lane = lane % (64'd1 << e);
            r = r | (lane << (16 * l));
        end
        return r;
    endfunction

    function automatic logic ready_for(input int mode, input int c);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            if (c >= 8 && c < 18) return 1'b0;
            return ((c % 4) == 0 || (c % 4) == 3) ? 1'b1 : 1'b0;
        end
        return ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
    endfunction

    // Run one job from a start pulse to done, checking every observable rule.
    task automatic run_job(input logic [8:0] base, input logic [9:0] len, input logic [4:0] q,
                           input int mode, input int restart_at,
                           input logic chk_first, input logic [63:0] exp_first);
        logic [63:0] exp_q[$];
        logic [63:0] got_q[$];
        logic [8:0]  addr_q[$];
        logic [8:0]  a;
        logic [63:0] prev_data = 64'd0;
        logic        prev_last = 1'b0, prev_stall = 1'b0, rdy;
        logic        busy_c1 = 1'b0, busy_at_done = 1'b1;
        int first_rd = -1, last_rd = -1, first_v = -1, first_acc = -1, last_acc = -1;
        int done_cyc = -1, issued = 0, accepted = 0, max_out = 0;
        int last_count = 0, last_idx = -1, stab_err = 0, bad_last = 0, c = 0;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 9'(i);
            exp_q.push_back(model_reduce(acc_mem[a], int'(q)));
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; length = len; logq = q; m_ready = 1'b0;
        while (done_cyc < 0 && c < 2000) begin
            @(negedge clk);
            c++;
            if (c == restart_at) begin
                start = 1'b1; base_addr = 9'h0AA; length = 10'd3; logq = 5'd3;
            end else begin
                start = 1'b0;
            end
            rdy = ready_for(mode, c);
            m_ready = rdy;
            if (c == 1) busy_c1 = busy;
            if (rd_en) begin
                addr_q.push_back(rd_addr);
                issued++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
                if (issued - accepted > max_out) max_out = issued - accepted;
            end
            if (prev_stall && !(m_valid && m_data == prev_data && m_last == prev_last)) stab_err++;
            if (m_last && !m_valid) bad_last++;
            if (m_valid) begin
                if (first_v < 0) first_v = c;
                if (rdy) begin
                    got_q.push_back(m_data);
                    if (m_last) begin
                        last_count++;
                        last_idx = got_q.size() - 1;
                    end
                    accepted++;
                    if (first_acc < 0) first_acc = c;
                    last_acc = c;
                end
            end
            prev_stall = m_valid && !rdy;
            prev_data  = m_data;
            prev_last  = m_last;
            if (done) begin
                done_cyc = c;
                busy_at_done = busy;
            end
        end
        m_ready = 1'b0;
        check("done_seen", 64'(done_cyc >= 0), 64'd1);
        if (len == 10'd0) begin
            check("empty_done_cycle", 64'(done_cyc), 64'd1);
            check("empty_no_rd_en", 64'(issued), 64'd0);
            check("empty_no_beats", 64'(got_q.size()), 64'd0);
            check("empty_not_busy", 64'(busy_c1), 64'd0);
        end else begin
            check("busy_after_start", 64'(busy_c1), 64'd1);
            check("first_rd_en_cycle", 64'(first_rd), 64'd1);
            check("first_valid_latency", 64'(first_v - first_rd), 64'd2);
            check("rd_en_count", 64'(issued), 64'(len));
            for (int i = 0; i < addr_q.size() && i < int'(len); i++) begin
                a = base + 9'(i);
                check("rd_addr_seq", 64'(addr_q[i]), 64'(a));
            end
            check("beat_count", 64'(got_q.size()), 64'(len));
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                check("beat_data", got_q[i], exp_q[i]);
            if (chk_first && got_q.size() > 0) check("first_word_const", got_q[0], exp_first);
            check("m_last_count", 64'(last_count), 64'd1);
            check("m_last_position", 64'(last_idx), 64'(int'(len) - 1));
            check("m_last_without_valid", 64'(bad_last), 64'd0);
            check("done_after_last_accept", 64'(done_cyc - last_acc), 64'd1);
            check("busy_low_at_done", 64'(busy_at_done), 64'd0);
            check("credit_bound", 64'(max_out <= 4), 64'd1);
            check("hold_until_ready", 64'(stab_err), 64'd0);
            if (mode == 0) begin
                check("beats_back_to_back", 64'(last_acc - first_acc), 64'(int'(len) - 1));
                check("rd_en_back_to_back", 64'(last_rd - first_rd), 64'(int'(len) - 1));
            end
        end
    endtask

    // Watch a few idle cycles: no read, no beat, not busy.
    task automatic idle_check(input string name, input int cycles);
        int bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (rd_en || m_valid || busy || done) bad++;
        end
        check(name, 64'(bad), 64'd0);
    endtask

    typedef struct {
        logic [8:0]  base;
        logic [9:0]  len;
        logic [4:0]  q;
        int          mode;
        logic        chk;
        logic [63:0] exp_first;
    } vec_t;

    vec_t vecs[8];

    initial begin
        for (int i = 0; i < 512; i++) acc_mem[i] = {$urandom, $urandom};
        for (int i = 16; i < 20; i++) acc_mem[i] = 64'h0001_8002_FFFF_7FFF;
        acc_mem[9'h1FE] = 64'h1111_2222_3333_01FE;
        acc_mem[9'h1FF] = 64'h1111_2222_3333_01FF;
        acc_mem[9'h000] = 64'h1111_2222_3333_0000;
        acc_mem[9'h001] = 64'h1111_2222_3333_0001;
        for (int i = 0; i < 8; i++) acc_mem[32 + i] = 64'hA000_0000_0000_0020 + 64'(i);

        vecs[0] = '{9'h010, 10'd4, 5'd15, 0, 1'b1, 64'h0001_0002_7FFF_7FFF};
        vecs[1] = '{9'h010, 10'd4, 5'd16, 0, 1'b1, 64'h0001_8002_FFFF_7FFF};
        vecs[2] = '{9'h010, 10'd4, 5'd12, 0, 1'b1, 64'h0001_0002_0FFF_0FFF};
        vecs[3] = '{9'h010, 10'd4, 5'd0,  0, 1'b1, 64'h0001_0000_0001_0001};
        vecs[4] = '{9'h010, 10'd4, 5'd20, 0, 1'b1, 64'h0001_8002_FFFF_7FFF};
        vecs[5] = '{9'h1FE, 10'd4, 5'd16, 0, 1'b1, 64'h1111_2222_3333_01FE};
        vecs[6] = '{9'h020, 10'd8, 5'd16, 1, 1'b1, 64'hA000_0000_0000_0020};
        vecs[7] = '{9'h030, 10'd0, 5'd16, 0, 1'b0, 64'd0};

        #12;
        check("reset_ctrl_outputs", 64'({rd_en, m_valid, m_last, busy, done}), 64'd0);
        check("reset_m_data", m_data, 64'd0);
        check("reset_rd_addr", 64'(rd_addr), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        idle_check("idle_after_reset", 3);

        for (int v = 0; v < 8; v++)
            run_job(vecs[v].base, vecs[v].len, vecs[v].q, vecs[v].mode, 0,
                    vecs[v].chk, vecs[v].exp_first);

        // start pulsed while busy must not disturb the job nor queue another.
        run_job(9'h010, 10'd4, 5'd15, 0, 2, 1'b1, 64'h0001_0002_7FFF_7FFF);
        idle_check("restart_ignored", 6);

        // Reset in the middle of a stalled job.
        @(negedge clk);
        start = 1'b1; base_addr = 9'h020; length = 10'd8; logq = 5'd16; m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midjob_reset_ctrl", 64'({rd_en, m_valid, m_last, busy, done}), 64'd0);
        check("midjob_reset_data", m_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        m_ready = 1'b1;
        idle_check("stale_data_discarded", 4);
        m_ready = 1'b0;
        run_job(9'h010, 10'd4, 5'd12, 0, 0, 1'b1, 64'h0001_0002_0FFF_0FFF);

        // Randomized jobs against the reference model.
        for (int r = 0; r < 8; r++)
            run_job(9'($urandom_range(0, 511)), 10'($urandom_range(1, 20)),
                    5'($urandom_range(0, 20)), 2, 0, 1'b0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
